dbus_console_slave: RTL and testbench
=====================================

# dbus_console_slave

Parametrised, synthesisable data-bus slave for the ARM9-compatible core's `ram_*` port. It combines a byte-writable word RAM with a memory-mapped console: status register, transmit FIFO and 8N1 UART transmitter. It sits between `arm9_compatiable_code` and the board pins, so the same firmware that prints through the console address in simulation also prints on hardware.

## Interface
- `RAM_AW`, default 9: RAM word-address width; depth is 2^RAM_AW words of 32 bits.
- `RAM_REGION`, default 4'h4: value of `ram_addr[31:28]` that selects RAM.
- `IO_BASE`, default 32'hE000_0000: console base address. STATUS is at +0, TXDATA is at +4.
- `FIFO_AW`, default 4: the TX FIFO holds 2^FIFO_AW bytes.
- `BAUD_DIV`, default 434: clocks per UART bit. Must be ≥2.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: synchronous, active-low reset.
- `ram_cen`, input, 1: bus access strobe.
- `ram_wen`, input, 1: 1 = write, 0 = read.
- `ram_flag`, input, 4: byte enables; bit n enables byte n.
- `ram_addr`, input, 32: byte address, word aligned.
- `ram_wdata`, input, 32: write data.
- `ram_rdata`, output, 32: registered read data.
- `uart_txd`, output, 1: serial output, idle high.
- `tx_busy`, output, 1: high while the FIFO is non-empty or the UART is not IDLE.

## Operation
- **RAM region** (`ram_addr[31:28]==RAM_REGION`):
  - Word index is `ram_addr[RAM_AW+1:2]`; higher address bits are ignored (aliasing).
  - A write updates only the bytes whose `ram_flag` bit is set.
  - A read returns the full word.
- **STATUS read** returns:
  - bit0: FIFO full.
  - bit1: FIFO empty.
  - bit2: `tx_busy`.
  - bit3: sticky overflow.
  - bits[FIFO_AW+8:8]: FIFO level.
  - All other bits: 0.
- **STATUS write** with `ram_flag[0]` set and `ram_wdata[3]==1` clears overflow. Other bits are ignored.
- **TXDATA write** with `ram_flag[0]` set pushes `ram_wdata[7:0]`.
  - If the FIFO is full, the byte is dropped and overflow is set.
  - A TXDATA read returns 0.
- **Unmapped accesses:**
  - Writes have no effect.
  - Reads leave `ram_rdata` unchanged.
- **FIFO:** circular buffer with pointers one bit wider than FIFO_AW; wrap-around is natural. Full and empty are decoded from the pointers.
- **UART FSM:** IDLE → START → DATA → STOP → (IDLE, or directly START if the FIFO is non-empty).
  - IDLE, FIFO non-empty: pop into the shift register, load the baud counter with BAUD_DIV-1, go to START.
  - Each state lasts BAUD_DIV clocks, counted down to 0.
  - START drives `uart_txd`=0.
  - DATA sends 8 bits, LSB first; a 3-bit counter selects the bit.
  - STOP drives `uart_txd`=1, then pops the next byte if available. Back-to-back frames have no extra idle clock.
- **Simultaneous push and pop:**
  - Neither full nor empty: both happen and the level is unchanged.
  - Full: full is evaluated before the edge, so the push is dropped even if a pop occurs in the same cycle.
  - Empty: a push is accepted, and the pop waits one cycle.
- **Reset values:**
  - `ram_rdata`=0, `uart_txd`=1, `tx_busy`=0.
  - FIFO empty, overflow=0, FSM IDLE, counters 0.
  - RAM contents are not reset.
- **Reset mid-frame:** the next clock with `rst`=0 aborts the frame; `uart_txd`=1 from that edge on. Queued bytes are discarded.

## Timing
- Read latency is 1 cycle: `ram_rdata` is valid on the edge after the cycle in which `ram_cen`=1 and `ram_wen`=0, and holds until the next valid read.
- RAM writes and FIFO pushes take effect at the edge of the access cycle. A read of the same address in the next cycle returns the new data. STATUS reflects the new level the cycle after the push.
- After a push into an empty FIFO with the FSM IDLE:
  - Pop occurs at edge +1.
  - `uart_txd` falls at edge +2.
  - `tx_busy` rises at edge +1.
- A frame is 10×BAUD_DIV clocks. `tx_busy` falls at the edge the FSM returns to IDLE with the FIFO empty.
- One access per cycle. There are no wait states and no back-pressure; the bus never stalls.

## Test plan
- **RAM byte enables:** write 32'h11223344 with flag 4'hF to 0x4000_0010, then 32'hAABBCCDD with flag 4'h5 to the same address. A read one cycle later returns 32'h11BB33DD.
- **Single character:** BAUD_DIV=4, write 0x41 to TXDATA. Expected:
  - `uart_txd` low for 4 clocks starting 2 edges after the write.
  - Then bits 1,0,0,0,0,0,1,0, each 4 clocks.
  - Then high for 4 clocks.
  - `tx_busy` drops 41 clocks after the write.
- **Overflow:** FIFO_AW=2. Write 6 bytes back-to-back. Expected:
  - STATUS shows full=1 and overflow=1.
  - Serial output contains exactly 5 bytes: 1 popped plus 4 queued.
  - Writing STATUS with bit3 set clears overflow.
- **Wrap-around:** stream 40 bytes with FIFO_AW=2, waiting for bit0==0 before each write. The serial output matches all 40 bytes in order with no gaps between frames.
- **Reset mid-frame:** assert `rst`=0 during DATA. The next edge gives `uart_txd`=1, STATUS=32'h2 on the next read, and `ram_rdata`=0.
- **Unmapped read:** read 0x4000_0000 (value V), then read 0x8000_0000. `ram_rdata` stays V.

Source files
------------

// File: rtl/dbus_console_slave.sv
// dbus_console_slave
//
// Data-bus slave for the core's ram_* port. It combines a byte-writable
// word RAM with a memory-mapped console: a STATUS register, a TX byte FIFO
// and an 8N1 UART transmitter.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous active-low reset
//   ram_cen    : access strobe (one access per cycle)
//   ram_wen    : 1 = write, 0 = read
//   ram_flag   : byte enables, bit n enables byte n
//   ram_addr   : word-aligned byte address
//   ram_wdata  : write data
//   ram_rdata  : registered read data (1-cycle latency, holds between reads)
//   uart_txd   : serial output, idle high
//   tx_busy    : FIFO non-empty or transmitter active
//
// Handshake: ram_cen acts as a valid that is always accepted. There is no
// ready; every access completes at the edge that ends its cycle, and read
// data appears on ram_rdata right after that edge.
//
// Address map
//   ram_addr[31:28] == RAM_REGION : RAM, word index ram_addr[RAM_AW+1:2]
//   IO_BASE + 0                   : STATUS {level, overflow, busy, empty, full}
//   IO_BASE + 4                   : TXDATA (write pushes a byte, read gives 0)
module dbus_console_slave #(
  parameter int          RAM_AW     = 9,
  parameter logic [3:0]  RAM_REGION = 4'h4,
  parameter logic [31:0] IO_BASE    = 32'hE000_0000,
  parameter int          FIFO_AW    = 4,
  parameter int          BAUD_DIV   = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_cen,
  input  logic        ram_wen,
  input  logic [3:0]  ram_flag,
  input  logic [31:0] ram_addr,
  input  logic [31:0] ram_wdata,
  output logic [31:0] ram_rdata,
  output logic        uart_txd,
  output logic        tx_busy
);

  localparam int            BW        = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam int            FD        = 2 ** FIFO_AW;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic              rd_en, wr_en;
  logic              ram_sel, stat_sel, txd_sel;
  logic [RAM_AW-1:0] ram_idx;

  assign rd_en    = ram_cen && !ram_wen;
  assign wr_en    = ram_cen &&  ram_wen;
  assign ram_sel  = (ram_addr[31:28] == RAM_REGION);
  // RAM decode wins so the console can never shadow RAM words.
  assign stat_sel = !ram_sel && (ram_addr == IO_BASE);
  assign txd_sel  = !ram_sel && (ram_addr == (IO_BASE + 32'd4));
  assign ram_idx  = ram_addr[RAM_AW+1:2];

  // ---------------------------------------------------------------------
  // Word RAM (contents not reset)
  // ---------------------------------------------------------------------
  logic [31:0] mem [2**RAM_AW];

  always_ff @(posedge clk) begin
    if (wr_en && ram_sel) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_flag[b]) mem[ram_idx][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------
  // TX FIFO: pointers carry one extra wrap bit
  // ---------------------------------------------------------------------
  logic [7:0]         fifo_mem [FD];
  logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   fifo_level;
  logic               fifo_full, fifo_empty;
  logic               push_req, push, pop;
  logic               ovf_q, ovf_d;
  logic               ovf_clr;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                      (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign fifo_level = wr_ptr_q - rd_ptr_q;

  assign push_req = wr_en && txd_sel && ram_flag[0];
  // Full is judged before the edge: a pop in the same cycle does not
  // make room for this push.
  assign push     = push_req && !fifo_full;
  assign ovf_clr  = wr_en && stat_sel && ram_flag[0] && ram_wdata[3];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[FIFO_AW-1:0]] <= ram_wdata[7:0];
  end

  // ---------------------------------------------------------------------
  // UART transmitter state
  // ---------------------------------------------------------------------
  uart_state_e   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          tx_busy_q, tx_busy_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   status_word;

  // STATUS layout: level in [FIFO_AW+8:8], flags in [3:0].
  always_comb begin
    status_word                = '0;
    status_word[0]             = fifo_full;
    status_word[1]             = fifo_empty;
    status_word[2]             = tx_busy_q;
    status_word[3]             = ovf_q;
    status_word[FIFO_AW+8:8]   = fifo_level;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      if (ram_sel)       rdata_d = mem[ram_idx];
      else if (stat_sel) rdata_d = status_word;
      else if (txd_sel)  rdata_d = '0;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (push_req && fifo_full) ovf_d = 1'b1;
    else if (ovf_clr)          ovf_d = 1'b0;
  end

  // UART next-state. txd is registered from the current state, so the line
  // follows the state by one clock; this is what places the start bit two
  // edges after a push into an idle console.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    txd_d   = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_mem[rd_ptr_q[FIFO_AW-1:0]];
          baud_d  = BAUD_LAST;
          bit_d   = 3'd0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        txd_d = 1'b0;
        if (baud_q == '0) begin
          baud_d  = BAUD_LAST;
          bit_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      ST_DATA: begin
        txd_d = shift_q[bit_q];
        if (baud_q == '0) begin
          baud_d = BAUD_LAST;
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      ST_STOP: begin
        txd_d = 1'b1;
        if (baud_q == '0) begin
          if (!fifo_empty) begin
            // Chain straight into the next start bit, no idle clock.
            pop     = 1'b1;
            shift_d = fifo_mem[rd_ptr_q[FIFO_AW-1:0]];
            baud_d  = BAUD_LAST;
            bit_d   = 3'd0;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Busy tracks the FSM's next state plus bytes already queued before this
  // edge, so it rises with the pop and drops on the edge the FSM goes idle.
  always_comb begin
    tx_busy_d = (state_d != ST_IDLE) || !fifo_empty;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      tx_busy_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ovf_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      tx_busy_q <= tx_busy_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ovf_q     <= ovf_d;
      rdata_q   <= rdata_d;
    end
  end

  assign ram_rdata = rdata_q;
  assign uart_txd  = txd_q;
  assign tx_busy   = tx_busy_q;

endmodule

// File: tb/tb_dbus_console_slave.sv
// Testbench for dbus_console_slave: small FIFO (4 bytes) and a fast UART
// (4 clocks per bit). A serial monitor decodes uart_txd into rx_q and
// records the edge on which each start bit begins in start_q.
module tb_dbus_console_slave;

  localparam int          BAUD    = 4;
  localparam int          FAW     = 2;
  localparam logic [31:0] A_STAT  = 32'hE000_0000;
  localparam logic [31:0] A_TX    = 32'hE000_0004;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ram_cen = 1'b0;
  logic        ram_wen = 1'b0;
  logic [3:0]  ram_flag = 4'h0;
  logic [31:0] ram_addr = 32'h0;
  logic [31:0] ram_wdata = 32'h0;
  logic [31:0] ram_rdata;
  logic        uart_txd;
  logic        tx_busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [7:0] rx_q[$];
  int         start_q[$];
  int         ferr = 0;
  logic [7:0] exp_q[$];

  dbus_console_slave #(
    .RAM_AW    (9),
    .RAM_REGION(4'h4),
    .IO_BASE   (32'hE000_0000),
    .FIFO_AW   (FAW),
    .BAUD_DIV  (BAUD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ram_cen  (ram_cen),
    .ram_wen  (ram_wen),
    .ram_flag (ram_flag),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .uart_txd (uart_txd),
    .tx_busy  (tx_busy)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // serial monitor: samples the middle of every bit period
  initial begin : monitor
    logic [7:0] b;
    int         s;
    forever begin
      @(posedge clk); #2;
      if (rst && uart_txd === 1'b0) begin
        s = cyc;
        repeat (2) @(posedge clk);
        #2;
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(posedge clk);
          #2;
          b[i] = uart_txd;
        end
        repeat (BAUD) @(posedge clk);
        #2;
        if (uart_txd !== 1'b1) ferr++;
        rx_q.push_back(b);
        start_q.push_back(s);
      end
    end
  end

  // driver tasks
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] f);
    @(negedge clk);
    ram_cen = 1'b1; ram_wen = 1'b1; ram_addr = a; ram_wdata = d; ram_flag = f;
    @(posedge clk); #1;
    ram_cen = 1'b0; ram_wen = 1'b0; ram_flag = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    ram_cen = 1'b1; ram_wen = 1'b0; ram_addr = a;
    @(posedge clk); #1;
    ram_cen = 1'b0;
    d = ram_rdata;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < budget) begin
      @(posedge clk); #1;
      if (tx_busy === 1'b0) begin ok = 1'b1; break; end
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // scenario tasks
  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (ram_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp %h", ram_rdata, 32'h0); end
    n_cmp++;
    if (uart_txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd got %b exp 1", uart_txd); end
    n_cmp++;
    if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", tx_busy); end
    @(negedge clk); rst = 1'b1;
    bus_read(A_STAT, d);
    n_cmp++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL reset_status got %h exp %h", d, 32'h2); end
  endtask

  task automatic test_ram();
    logic [31:0] d;
    bus_write(32'h4000_0010, 32'h1122_3344, 4'hF);
    bus_write(32'h4000_0010, 32'hAABB_CCDD, 4'h5);
    bus_read(32'h4000_0010, d);
    n_cmp++;
    if (d !== 32'h11BB_33DD) begin n_fail++; $display("FAIL ram_byte_en got %h exp %h", d, 32'h11BB_33DD); end
    bus_read(32'h4000_0810, d);
    n_cmp++;
    if (d !== 32'h11BB_33DD) begin n_fail++; $display("FAIL ram_alias got %h exp %h", d, 32'h11BB_33DD); end
    bus_write(32'h8000_0010, 32'hFFFF_FFFF, 4'hF);
    bus_read(32'h4000_0010, d);
    n_cmp++;
    if (d !== 32'h11BB_33DD) begin n_fail++; $display("FAIL unmapped_write got %h exp %h", d, 32'h11BB_33DD); end
    bus_write(32'h4000_0000, 32'hCAFE_F00D, 4'hF);
    bus_read(32'h4000_0000, d);
    n_cmp++;
    if (d !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL ram_word got %h exp %h", d, 32'hCAFE_F00D); end
    bus_read(32'h8000_0000, d);
    n_cmp++;
    if (d !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL unmapped_read got %h exp %h", d, 32'hCAFE_F00D); end
    bus_read(A_TX, d);
    n_cmp++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL txdata_read got %h exp %h", d, 32'h0); end
  endtask

  task automatic test_single_char();
    logic [7:0] ch = 8'h41;
    logic       e_txd, e_busy;
    rx_q.delete(); start_q.delete();
    bus_write(A_TX, 32'h41, 4'h1);
    n_cmp++;
    if (tx_busy !== 1'b0 || uart_txd !== 1'b1) begin
      n_fail++; $display("FAIL char_k0 got busy=%b txd=%b exp busy=0 txd=1", tx_busy, uart_txd);
    end
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #1;
      if (k < 2)       e_txd = 1'b1;
      else if (k < 6)  e_txd = 1'b0;
      else if (k < 38) e_txd = ch[(k - 6) / 4];
      else             e_txd = 1'b1;
      e_busy = (k <= 40);
      n_cmp++;
      if (uart_txd !== e_txd) begin n_fail++; $display("FAIL char_txd k=%0d got %b exp %b", k, uart_txd, e_txd); end
      n_cmp++;
      if (tx_busy !== e_busy) begin n_fail++; $display("FAIL char_busy k=%0d got %b exp %b", k, tx_busy, e_busy); end
    end
    n_cmp++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h41) begin
      n_fail++; $display("FAIL char_rx got %0d bytes first %h exp 1 byte 41", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_tx_flag();
    logic [31:0] d;
    bus_write(A_TX, 32'h77, 4'hE);
    bus_read(A_STAT, d);
    n_cmp++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL tx_flag0_clear got %h exp %h", d, 32'h2); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    bit          ok;
    rx_q.delete(); start_q.delete(); exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      bus_write(A_TX, 32'hA0 + i, 4'h1);
      if (i < 5) exp_q.push_back(8'(8'hA0 + i));
    end
    bus_read(A_STAT, d);
    n_cmp++;
    if (d !== 32'h40D) begin n_fail++; $display("FAIL ovf_status got %h exp %h", d, 32'h40D); end
    bus_write(A_STAT, 32'h8, 4'hE);
    bus_read(A_STAT, d);
    n_cmp++;
    if (d !== 32'h40D) begin n_fail++; $display("FAIL ovf_keep got %h exp %h", d, 32'h40D); end
    bus_write(A_STAT, 32'h8, 4'h1);
    bus_read(A_STAT, d);
    n_cmp++;
    if (d !== 32'h405) begin n_fail++; $display("FAIL ovf_clear got %h exp %h", d, 32'h405); end
    wait_idle(600, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL ovf_idle got busy exp idle within 600 clocks"); end
    n_cmp++;
    if (rx_q.size() != 5) begin n_fail++; $display("FAIL ovf_count got %0d exp 5", rx_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      n_cmp++;
      if (rx_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL ovf_byte got %h exp %h", rx_q[0], exp_q[0]); end
      void'(rx_q.pop_front()); void'(exp_q.pop_front());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    bit          ok;
    int          tries, gaps;
    rx_q.delete(); start_q.delete(); exp_q.delete();
    for (int i = 0; i < 40; i++) begin
      tries = 0;
      do begin
        bus_read(A_STAT, d);
        tries++;
      end while (d[0] !== 1'b0 && tries < 200);
      n_cmp++;
      if (d[0] !== 1'b0) begin n_fail++; $display("FAIL wrap_poll i=%0d got full exp not full", i); end
      bus_write(A_TX, 32'((i * 37 + 5) & 8'hFF), 4'h1);
      exp_q.push_back(8'((i * 37 + 5) & 8'hFF));
    end
    wait_idle(2000, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL wrap_idle got busy exp idle within 2000 clocks"); end
    n_cmp++;
    if (rx_q.size() != 40) begin n_fail++; $display("FAIL wrap_count got %0d exp 40", rx_q.size()); end
    gaps = 0;
    for (int i = 1; i < start_q.size(); i++) begin
      if (start_q[i] - start_q[i-1] != 10 * BAUD) gaps++;
    end
    n_cmp++;
    if (gaps != 0) begin n_fail++; $display("FAIL wrap_gaps got %0d gaps exp 0", gaps); end
    n_cmp++;
    if (ferr != 0) begin n_fail++; $display("FAIL framing got %0d errors exp 0", ferr); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      n_cmp++;
      if (rx_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL wrap_byte got %h exp %h", rx_q[0], exp_q[0]); end
      void'(rx_q.pop_front()); void'(exp_q.pop_front());
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d;
    int          lows;
    bus_write(32'h4000_0020, 32'h1234_5678, 4'hF);
    bus_write(A_TX, 32'h00, 4'h1);
    bus_write(A_TX, 32'h5A, 4'h1);
    bus_read(32'h4000_0020, d);
    n_cmp++;
    if (d !== 32'h1234_5678) begin n_fail++; $display("FAIL mid_pre_read got %h exp %h", d, 32'h1234_5678); end
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if (uart_txd !== 1'b0) begin n_fail++; $display("FAIL mid_data_low got %b exp 0", uart_txd); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (uart_txd !== 1'b1) begin n_fail++; $display("FAIL mid_txd got %b exp 1", uart_txd); end
    n_cmp++;
    if (ram_rdata !== 32'h0) begin n_fail++; $display("FAIL mid_rdata got %h exp %h", ram_rdata, 32'h0); end
    n_cmp++;
    if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b exp 0", tx_busy); end
    @(negedge clk); rst = 1'b1;
    bus_read(A_STAT, d);
    n_cmp++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL mid_status got %h exp %h", d, 32'h2); end
    lows = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (uart_txd !== 1'b1) lows++;
    end
    n_cmp++;
    if (lows != 0) begin n_fail++; $display("FAIL mid_discard got %0d low clocks exp 0", lows); end
  endtask

  // sequence + final report
  initial begin
    test_reset();
    test_ram();
    test_single_char();
    test_tx_flag();
    test_overflow();
    test_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
